// File: rtl/ctrl_pkg.sv
// Shared encodings and control-bundle types for the pipelined control unit.
package ctrl_pkg;

  // Primary opcodes, instruction bits 31:26
  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // ALU operation classes handed to the ALU control block
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  // Immediate extension modes
  localparam logic [1:0] EXT_SIGN  = 2'b00;
  localparam logic [1:0] EXT_ZERO  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic [1:0] alu_op;
    logic [1:0] ext_op;
  } ex_ctrl_t;

  typedef struct packed {
    logic read;
    logic write;
    logic branch;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  typedef struct packed {
    ex_ctrl_t  ex;
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
  } ctrl_t;

  // A bubble does nothing in any stage
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_pipe_if.sv
// ID-stage inputs and per-stage control outputs of the pipelined control unit.
interface ctrl_pipe_if #(
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 2
);
  logic              id_valid;
  logic [5:0]        id_opcode;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic              branch_taken;

  logic               id_jump;
  logic               id_illegal;
  logic               load_use_stall;
  logic               ex_reg_dst;
  logic               ex_alu_src;
  logic [ALUOP_W-1:0] ex_alu_op;
  logic [1:0]         ex_ext_op;
  logic               mem_read;
  logic               mem_write;
  logic               mem_branch;
  logic               wb_reg_write;
  logic               wb_mem_to_reg;
  logic [REG_AW-1:0]  wb_dst;

  // Datapath / pipeline front end side
  modport master (
    output id_valid, id_opcode, id_rs, id_rt, id_rd, branch_taken,
    input  id_jump, id_illegal, load_use_stall,
    input  ex_reg_dst, ex_alu_src, ex_alu_op, ex_ext_op,
    input  mem_read, mem_write, mem_branch,
    input  wb_reg_write, wb_mem_to_reg, wb_dst
  );

  // Control unit side
  modport slave (
    input  id_valid, id_opcode, id_rs, id_rt, id_rd, branch_taken,
    output id_jump, id_illegal, load_use_stall,
    output ex_reg_dst, ex_alu_src, ex_alu_op, ex_ext_op,
    output mem_read, mem_write, mem_branch,
    output wb_reg_write, wb_mem_to_reg, wb_dst
  );
endinterface

// File: rtl/ctrl_pipe_decode.sv
// Combinational opcode decoder: control bundle plus jump/illegal flags.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter bit LUI_EN = 1'b1
) (
  input  logic       valid,
  input  logic [5:0] opcode,
  output ctrl_t      ctrl,
  output logic       jump,
  output logic       illegal
);

  ctrl_t dec;
  logic  op_jump;
  logic  op_bad;

  // Raw opcode decode, independent of slot validity
  always_comb begin
    dec     = CTRL_BUBBLE;
    op_jump = 1'b0;
    op_bad  = 1'b0;
    case (opcode)
      OP_R: begin
        dec.ex.reg_dst   = 1'b1;
        dec.ex.alu_op    = ALUOP_FUNCT;
        dec.wb.reg_write = 1'b1;
      end
      OP_ADDI, OP_ADDIU: begin
        dec.ex.alu_src   = 1'b1;
        dec.ex.ext_op    = EXT_SIGN;
        dec.wb.reg_write = 1'b1;
      end
      OP_LUI: begin
        if (LUI_EN) begin
          dec.ex.alu_src   = 1'b1;
          dec.ex.ext_op    = EXT_UPPER;
          dec.wb.reg_write = 1'b1;
        end else begin
          op_bad = 1'b1;
        end
      end
      OP_LW: begin
        dec.ex.alu_src    = 1'b1;
        dec.mem.read      = 1'b1;
        dec.wb.mem_to_reg = 1'b1;
        dec.wb.reg_write  = 1'b1;
      end
      OP_SW: begin
        dec.ex.alu_src = 1'b1;
        dec.mem.write  = 1'b1;
      end
      OP_BEQ: begin
        dec.mem.branch = 1'b1;
        dec.ex.alu_op  = ALUOP_SUB;
      end
      OP_ORI: begin
        dec.ex.alu_src   = 1'b1;
        dec.ex.alu_op    = ALUOP_OR;
        dec.ex.ext_op    = EXT_ZERO;
        dec.wb.reg_write = 1'b1;
      end
      OP_J: begin
        op_jump = 1'b1;
      end
      default: begin
        op_bad = 1'b1;
      end
    endcase
  end

  // An empty ID slot produces nothing at all
  always_comb begin
    ctrl    = valid ? dec : CTRL_BUBBLE;
    jump    = valid & op_jump;
    illegal = valid & op_bad;
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control unit: decode in ID, carry the bundle through ID/EX,
// EX/MEM and MEM/WB, with load-use stall and branch flush handling.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int ALUOP_W   = 2,
  parameter bit HAZARD_EN = 1'b1,
  parameter bit LUI_EN    = 1'b1
) (
  input logic        clk,
  input logic        rst_n,
  ctrl_pipe_if.slave bus
);

  ctrl_t             id_ctrl;
  logic              load_use;

  // ID/EX keeps rt/rd so the destination mux lives in the EX stage
  ctrl_t             idex_ctrl_q,  idex_ctrl_d;
  logic [REG_AW-1:0] idex_rt_q,    idex_rt_d;
  logic [REG_AW-1:0] idex_rd_q,    idex_rd_d;
  logic [REG_AW-1:0] ex_dst;

  mem_ctrl_t         exmem_mem_q,  exmem_mem_d;
  wb_ctrl_t          exmem_wb_q,   exmem_wb_d;
  logic [REG_AW-1:0] exmem_dst_q,  exmem_dst_d;

  wb_ctrl_t          memwb_wb_q,   memwb_wb_d;
  logic [REG_AW-1:0] memwb_dst_q,  memwb_dst_d;

  ctrl_decode #(
    .LUI_EN (LUI_EN)
  ) u_decode (
    .valid   (bus.id_valid),
    .opcode  (bus.id_opcode),
    .ctrl    (id_ctrl),
    .jump    (bus.id_jump),
    .illegal (bus.id_illegal)
  );

  // Load in EX whose target is read by the instruction in ID
  always_comb begin
    load_use = HAZARD_EN && idex_ctrl_q.mem.read && (idex_rt_q != '0) &&
               ((idex_rt_q == bus.id_rs) || (idex_rt_q == bus.id_rt)) &&
               bus.id_valid;
  end

  // ID/EX next state: flush or stall or empty slot all become a bubble
  always_comb begin
    idex_ctrl_d = id_ctrl;
    idex_rt_d   = bus.id_rt;
    idex_rd_d   = bus.id_rd;
    if (bus.branch_taken || load_use || !bus.id_valid) begin
      idex_ctrl_d = CTRL_BUBBLE;
      idex_rt_d   = '0;
      idex_rd_d   = '0;
    end
  end

  // EX-stage destination select, then EX/MEM next state (flushed on taken branch)
  always_comb begin
    ex_dst      = idex_ctrl_q.ex.reg_dst ? idex_rd_q : idex_rt_q;
    exmem_mem_d = idex_ctrl_q.mem;
    exmem_wb_d  = idex_ctrl_q.wb;
    exmem_dst_d = ex_dst;
    if (bus.branch_taken) begin
      exmem_mem_d = CTRL_BUBBLE.mem;
      exmem_wb_d  = CTRL_BUBBLE.wb;
      exmem_dst_d = '0;
    end
  end

  // MEM/WB always advances; the branch in MEM carries no write of its own
  always_comb begin
    memwb_wb_d  = exmem_wb_q;
    memwb_dst_d = exmem_dst_q;
  end

  // Stage registers, cleared asynchronously so in-flight work is discarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_ctrl_q <= CTRL_BUBBLE;
      idex_rt_q   <= '0;
      idex_rd_q   <= '0;
      exmem_mem_q <= CTRL_BUBBLE.mem;
      exmem_wb_q  <= CTRL_BUBBLE.wb;
      exmem_dst_q <= '0;
      memwb_wb_q  <= CTRL_BUBBLE.wb;
      memwb_dst_q <= '0;
    end else begin
      idex_ctrl_q <= idex_ctrl_d;
      idex_rt_q   <= idex_rt_d;
      idex_rd_q   <= idex_rd_d;
      exmem_mem_q <= exmem_mem_d;
      exmem_wb_q  <= exmem_wb_d;
      exmem_dst_q <= exmem_dst_d;
      memwb_wb_q  <= memwb_wb_d;
      memwb_dst_q <= memwb_dst_d;
    end
  end

  assign bus.load_use_stall = load_use;
  assign bus.ex_reg_dst     = idex_ctrl_q.ex.reg_dst;
  assign bus.ex_alu_src     = idex_ctrl_q.ex.alu_src;
  assign bus.ex_alu_op      = ALUOP_W'(idex_ctrl_q.ex.alu_op);
  assign bus.ex_ext_op      = idex_ctrl_q.ex.ext_op;
  assign bus.mem_read       = exmem_mem_q.read;
  assign bus.mem_write      = exmem_mem_q.write;
  assign bus.mem_branch     = exmem_mem_q.branch;
  assign bus.wb_reg_write   = memwb_wb_q.reg_write;
  assign bus.wb_mem_to_reg  = memwb_wb_q.mem_to_reg;
  assign bus.wb_dst         = memwb_dst_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: a default instance and one with hazard
// detection and lui decoding disabled, both fed the same ID stream.
module tb_ctrl_pipe;
  import ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  ctrl_pipe_if #(.REG_AW(5), .ALUOP_W(2)) bus_a ();
  ctrl_pipe_if #(.REG_AW(5), .ALUOP_W(2)) bus_b ();

  ctrl_pipe #(.REG_AW(5), .ALUOP_W(2), .HAZARD_EN(1'b1), .LUI_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  ctrl_pipe #(.REG_AW(5), .ALUOP_W(2), .HAZARD_EN(1'b0), .LUI_EN(1'b0)) dut_p (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] regs_a, regs_b;
  assign regs_a = {bus_a.ex_reg_dst, bus_a.ex_alu_src, bus_a.ex_alu_op, bus_a.ex_ext_op,
                   bus_a.mem_read, bus_a.mem_write, bus_a.mem_branch,
                   bus_a.wb_reg_write, bus_a.wb_mem_to_reg, bus_a.wb_dst};
  assign regs_b = {bus_b.ex_reg_dst, bus_b.ex_alu_src, bus_b.ex_alu_op, bus_b.ex_ext_op,
                   bus_b.mem_read, bus_b.mem_write, bus_b.mem_branch,
                   bus_b.wb_reg_write, bus_b.wb_mem_to_reg, bus_b.wb_dst};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h (t=%0t)", tag, got, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] op,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    bus_a.id_valid  = v;  bus_b.id_valid  = v;
    bus_a.id_opcode = op; bus_b.id_opcode = op;
    bus_a.id_rs     = rs; bus_b.id_rs     = rs;
    bus_a.id_rt     = rt; bus_b.id_rt     = rt;
    bus_a.id_rd     = rd; bus_b.id_rd     = rd;
  endtask

  task automatic set_branch(input logic b);
    bus_a.branch_taken = b;
    bus_b.branch_taken = b;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [5:0] seq_op  [4];
  logic [4:0] seq_rt  [4];
  logic [4:0] seq_rd  [4];
  logic [1:0] seq_alu [4];
  logic [4:0] hz_rs;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    seq_op  = '{OP_R, OP_ORI, OP_SW, OP_BEQ};
    seq_rt  = '{5'd2, 5'd4, 5'd6, 5'd2};
    seq_rd  = '{5'd3, 5'd0, 5'd0, 5'd0};
    seq_alu = '{2'b10, 2'b11, 2'b00, 2'b01};

    // Reset held low with a lw in ID: nothing registers
    rst_n = 1'b0;
    set_branch(1'b0);
    drive(1'b1, OP_LW, 5'd1, 5'd2, 5'd0);
    tick();
    check("rst_regs_a", 32'(regs_a), 32'd0);
    tick();
    check("rst_regs_a2", 32'(regs_a), 32'd0);
    check("rst_regs_b", 32'(regs_b), 32'd0);
    rst_n = 1'b1;
    tick();
    check("lw_ex_alu_src", 32'(bus_a.ex_alu_src), 32'd1);
    check("lw_wb_before", 32'(bus_a.wb_reg_write), 32'd0);
    drive(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
    tick();
    check("lw_mem_read", 32'(bus_a.mem_read), 32'd1);
    tick();
    check("lw_wb_reg_write", 32'(bus_a.wb_reg_write), 32'd1);
    check("lw_wb_mem_to_reg", 32'(bus_a.wb_mem_to_reg), 32'd1);
    check("lw_wb_dst", 32'(bus_a.wb_dst), 32'd2);
    idle(3);

    // R, ori, sw, beq back to back
    for (int c = 0; c < 7; c++) begin
      if (c < 4) drive(1'b1, seq_op[c], 5'd1, seq_rt[c], seq_rd[c]);
      else       drive(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
      tick();
      check($sformatf("seq%0d_ex_alu_op", c), 32'(bus_a.ex_alu_op),
            (c < 4) ? 32'(seq_alu[c]) : 32'd0);
      check($sformatf("seq%0d_mem_write", c), 32'(bus_a.mem_write), (c == 3) ? 32'd1 : 32'd0);
      check($sformatf("seq%0d_wb_reg_write", c), 32'(bus_a.wb_reg_write),
            (c == 2 || c == 3) ? 32'd1 : 32'd0);
      if (c == 2) check("seq_wb_dst_r", 32'(bus_a.wb_dst), 32'd3);
      if (c == 3) check("seq_wb_dst_ori", 32'(bus_a.wb_dst), 32'd4);
    end
    idle(2);

    // Load-use: lw rt=5 then R-type reading r5
    drive(1'b1, OP_LW, 5'd1, 5'd5, 5'd0);
    tick();
    drive(1'b1, OP_R, 5'd5, 5'd7, 5'd8);
    #1;
    check("lu_stall", 32'(bus_a.load_use_stall), 32'd1);
    check("lu_stall_hz_off", 32'(bus_b.load_use_stall), 32'd0);
    tick();
    check("lu_bubble_alu_op", 32'(bus_a.ex_alu_op), 32'd0);
    check("lu_bubble_reg_dst", 32'(bus_a.ex_reg_dst), 32'd0);
    check("lu_stall_cleared", 32'(bus_a.load_use_stall), 32'd0);
    check("lu_mem_read", 32'(bus_a.mem_read), 32'd1);
    tick();
    check("lu_add_alu_op", 32'(bus_a.ex_alu_op), 32'd2);
    check("lu_add_reg_dst", 32'(bus_a.ex_reg_dst), 32'd1);
    drive(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
    tick();
    tick();
    check("lu_add_wb_dst", 32'(bus_a.wb_dst), 32'd8);
    check("lu_add_wb_reg_write", 32'(bus_a.wb_reg_write), 32'd1);
    idle(2);

    // Same pair through r0: never a hazard
    drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd0);
    tick();
    drive(1'b1, OP_R, 5'd0, 5'd7, 5'd8);
    #1;
    check("lu0_no_stall", 32'(bus_a.load_use_stall), 32'd0);
    tick();
    check("lu0_add_alu_op", 32'(bus_a.ex_alu_op), 32'd2);
    idle(3);

    // Flush: beq in MEM, lw in EX, sw in ID (second pass also hazards)
    for (int v = 0; v < 2; v++) begin
      hz_rs = (v == 1) ? 5'd9 : 5'd1;
      drive(1'b1, OP_BEQ, 5'd1, 5'd2, 5'd0);
      tick();
      drive(1'b1, OP_LW, 5'd1, 5'd9, 5'd0);
      tick();
      drive(1'b1, OP_SW, hz_rs, 5'd10, 5'd0);
      set_branch(1'b1);
      #1;
      check($sformatf("fl%0d_mem_branch", v), 32'(bus_a.mem_branch), 32'd1);
      check($sformatf("fl%0d_stall", v), 32'(bus_a.load_use_stall), 32'(v));
      tick();
      set_branch(1'b0);
      drive(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
      check($sformatf("fl%0d_mem_read", v), 32'(bus_a.mem_read), 32'd0);
      check($sformatf("fl%0d_ex_alu_src", v), 32'(bus_a.ex_alu_src), 32'd0);
      check($sformatf("fl%0d_wb_beq", v), 32'(bus_a.wb_reg_write), 32'd0);
      tick();
      check($sformatf("fl%0d_mem_write", v), 32'(bus_a.mem_write), 32'd0);
      check($sformatf("fl%0d_mem_read2", v), 32'(bus_a.mem_read), 32'd0);
      check($sformatf("fl%0d_wb_lw", v), 32'(bus_a.wb_reg_write), 32'd0);
      tick();
      check($sformatf("fl%0d_wb_sw", v), 32'(bus_a.wb_reg_write), 32'd0);
      check($sformatf("fl%0d_wb_m2r", v), 32'(bus_a.wb_mem_to_reg), 32'd0);
      idle(2);
    end

    // Illegal, jump and lui handling
    drive(1'b1, 6'b111111, 5'd1, 5'd2, 5'd3);
    #1;
    check("ill_flag", 32'(bus_a.id_illegal), 32'd1);
    check("ill_no_jump", 32'(bus_a.id_jump), 32'd0);
    tick();
    check("ill_bundle", 32'(regs_a[15:10]), 32'd0);
    drive(1'b1, OP_J, 5'd0, 5'd0, 5'd0);
    #1;
    check("j_flag", 32'(bus_a.id_jump), 32'd1);
    check("j_not_illegal", 32'(bus_a.id_illegal), 32'd0);
    drive(1'b0, OP_J, 5'd0, 5'd0, 5'd0);
    #1;
    check("j_invalid_slot", 32'(bus_a.id_jump), 32'd0);
    drive(1'b1, OP_LUI, 5'd0, 5'd11, 5'd0);
    #1;
    check("lui_legal", 32'(bus_a.id_illegal), 32'd0);
    check("lui_illegal_off", 32'(bus_b.id_illegal), 32'd1);
    tick();
    check("lui_ext_op", 32'(bus_a.ex_ext_op), 32'd2);
    check("lui_alu_src", 32'(bus_a.ex_alu_src), 32'd1);
    check("lui_off_ext_op", 32'(bus_b.ex_ext_op), 32'd0);
    check("lui_off_alu_src", 32'(bus_b.ex_alu_src), 32'd0);
    idle(3);
    tick();
    check("ill_wb_reg_write", 32'(bus_a.wb_reg_write), 32'd0);

    // Asynchronous reset with all three stages occupied
    drive(1'b1, OP_R, 5'd1, 5'd2, 5'd3);
    tick();
    drive(1'b1, OP_ORI, 5'd1, 5'd4, 5'd0);
    tick();
    drive(1'b1, OP_LW, 5'd1, 5'd5, 5'd0);
    tick();
    check("ar_full_wb", 32'(bus_a.wb_reg_write), 32'd1);
    check("ar_full_ex", 32'(bus_a.ex_alu_src), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_regs_a", 32'(regs_a), 32'd0);
    check("ar_regs_b", 32'(regs_b), 32'd0);
    tick();
    check("ar_regs_held", 32'(regs_a), 32'd0);
    drive(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
    rst_n = 1'b1;
    tick();
    check("ar_after_release", 32'(regs_a), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
